// File: rtl/hwpe_tcdm_streamer.sv
// APB-configured copy/fill engine that moves words through N_PORTS parallel TCDM lanes.
// Each beat covers up to N_PORTS consecutive words; lanes handshake independently.
module hwpe_tcdm_streamer #(
   parameter int unsigned N_PORTS        = 4,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH      = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          test_mode_i,
   input  logic [APB_ADDR_WIDTH-1:0]     paddr_i,
   input  logic [31:0]                   pwdata_i,
   input  logic                          pwrite_i,
   input  logic                          psel_i,
   input  logic                          penable_i,
   output logic [31:0]                   prdata_o,
   output logic                          pready_o,
   output logic                          pslverr_o,
   output logic [N_PORTS-1:0]            tcdm_req_o,
   input  logic [N_PORTS-1:0]            tcdm_gnt_i,
   output logic [N_PORTS-1:0][31:0]      tcdm_add_o,
   output logic [N_PORTS-1:0]            tcdm_wen_o,
   output logic [N_PORTS-1:0][3:0]       tcdm_be_o,
   output logic [N_PORTS-1:0][31:0]      tcdm_wdata_o,
   input  logic [N_PORTS-1:0][31:0]      tcdm_r_rdata_i,
   input  logic [N_PORTS-1:0]            tcdm_r_valid_i,
   output logic [1:0]                    evt_o,
   output logic                          busy_o
);

   localparam int unsigned OFF_WIDTH = 5;
   localparam logic [OFF_WIDTH-1:0] OFF_CTRL    = 5'h00;
   localparam logic [OFF_WIDTH-1:0] OFF_STATUS  = 5'h04;
   localparam logic [OFF_WIDTH-1:0] OFF_SRC     = 5'h08;
   localparam logic [OFF_WIDTH-1:0] OFF_DST     = 5'h0C;
   localparam logic [OFF_WIDTH-1:0] OFF_LEN     = 5'h10;
   localparam logic [OFF_WIDTH-1:0] OFF_PATTERN = 5'h14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_WR_REQ,
      ST_DONE,
      ST_ERR
   } state_e;

   state_e                   state_q, state_d;
   logic [31:0]              src_q, dst_q, pattern_q;
   logic [LEN_WIDTH-1:0]     len_q;
   logic [LEN_WIDTH-1:0]     rem_q, rem_d, widx_q, widx_d;
   logic                     mode_q, mode_d, done_q, done_d, err_q, err_d;
   logic [N_PORTS-1:0]       gnt_flag_q, gnt_flag_d, rv_flag_q, rv_flag_d;
   logic [N_PORTS-1:0][31:0] rbuf_q, rbuf_d;

   logic [OFF_WIDTH-1:0]     reg_off;
   logic                     apb_access, reg_hit, reg_wr, busy;
   logic                     start, clr_status;
   logic [31:0]              reg_rdata;
   logic [N_PORTS-1:0]       lane_act, lane_req, gnt_now, rv_now;
   logic [LEN_WIDTH-1:0]     beat_words;
   logic                     xfer_st;
   logic                     unused_ok;

   assign unused_ok = ^{test_mode_i, paddr_i[APB_ADDR_WIDTH-1:OFF_WIDTH]};

   // APB decode: zero wait states, read data and error only during the access phase
   assign reg_off    = paddr_i[OFF_WIDTH-1:0];
   assign apb_access = psel_i & penable_i;
   assign busy       = (state_q != ST_IDLE);
   assign reg_wr     = apb_access & pwrite_i & reg_hit & ~busy;
   assign start      = reg_wr & (reg_off == OFF_CTRL) & pwdata_i[0];
   assign clr_status = reg_wr & (reg_off == OFF_CTRL) & pwdata_i[2];

   always_comb begin
      reg_hit   = 1'b1;
      reg_rdata = '0;
      case (reg_off)
         OFF_CTRL:    reg_rdata = '0;
         OFF_STATUS:  reg_rdata = {29'd0, err_q, done_q, busy};
         OFF_SRC:     reg_rdata = src_q;
         OFF_DST:     reg_rdata = dst_q;
         OFF_LEN:     reg_rdata = 32'(len_q);
         OFF_PATTERN: reg_rdata = pattern_q;
         default:     reg_hit   = 1'b0;
      endcase
   end

   assign prdata_o  = apb_access ? reg_rdata : '0;
   assign pslverr_o = apb_access & ~reg_hit;
   assign pready_o  = 1'b1;

   // Configuration registers, frozen while the engine is running
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         pattern_q <= '0;
      end else if (reg_wr) begin
         if (reg_off == OFF_SRC)     src_q     <= pwdata_i;
         if (reg_off == OFF_DST)     dst_q     <= pwdata_i;
         if (reg_off == OFF_LEN)     len_q     <= pwdata_i[LEN_WIDTH-1:0];
         if (reg_off == OFF_PATTERN) pattern_q <= pwdata_i;
      end
   end

   // Lanes active in the current beat: min(N_PORTS, remaining)
   always_comb begin
      for (int unsigned l = 0; l < N_PORTS; l++) begin
         lane_act[l] = (rem_q > LEN_WIDTH'(l));
      end
   end

   assign beat_words = (rem_q > LEN_WIDTH'(N_PORTS)) ? LEN_WIDTH'(N_PORTS) : rem_q;
   assign xfer_st    = (state_q == ST_RD_REQ) | (state_q == ST_WR_REQ);
   assign lane_req   = {N_PORTS{xfer_st}} & lane_act & ~gnt_flag_q;
   assign gnt_now    = gnt_flag_q | (tcdm_gnt_i & lane_req);
   assign rv_now     = rv_flag_q | (tcdm_r_valid_i & gnt_flag_q & lane_act);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         rem_q      <= '0;
         widx_q     <= '0;
         mode_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         gnt_flag_q <= '0;
         rv_flag_q  <= '0;
         rbuf_q     <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         widx_q     <= widx_d;
         mode_q     <= mode_d;
         done_q     <= done_d;
         err_q      <= err_d;
         gnt_flag_q <= gnt_flag_d;
         rv_flag_q  <= rv_flag_d;
         rbuf_q     <= rbuf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      widx_d     = widx_q;
      mode_d     = mode_q;
      done_d     = done_q;
      err_d      = err_q;
      gnt_flag_d = gnt_flag_q;
      rv_flag_d  = rv_flag_q;
      rbuf_d     = rbuf_q;
      case (state_q)
         ST_IDLE: begin
            if (clr_status || start) begin
               done_d = 1'b0;
               err_d  = 1'b0;
            end
            if (start) begin
               mode_d     = pwdata_i[1];
               rem_d      = len_q;
               widx_d     = '0;
               gnt_flag_d = '0;
               rv_flag_d  = '0;
               if ((!pwdata_i[1] && (src_q[1:0] != 2'b00)) || (dst_q[1:0] != 2'b00)) begin
                  state_d = ST_ERR;
               end else if (len_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = pwdata_i[1] ? ST_WR_REQ : ST_RD_REQ;
               end
            end
         end
         ST_RD_REQ: begin
            gnt_flag_d = gnt_now;
            rv_flag_d  = rv_now;
            for (int unsigned l = 0; l < N_PORTS; l++) begin
               if (tcdm_r_valid_i[l] && gnt_flag_q[l] && !rv_flag_q[l]) begin
                  rbuf_d[l] = tcdm_r_rdata_i[l];
               end
            end
            if ((rv_now & lane_act) == lane_act) begin
               state_d    = ST_WR_REQ;
               gnt_flag_d = '0;
               rv_flag_d  = '0;
            end
         end
         ST_WR_REQ: begin
            gnt_flag_d = gnt_now;
            if ((gnt_now & lane_act) == lane_act) begin
               rem_d      = rem_q - beat_words;
               widx_d     = widx_q + LEN_WIDTH'(N_PORTS);
               gnt_flag_d = '0;
               rv_flag_d  = '0;
               if (rem_q == beat_words) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = mode_q ? ST_WR_REQ : ST_RD_REQ;
               end
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Lane outputs decode straight from state and per-lane flags, so reset drops them at once
   always_comb begin
      for (int unsigned l = 0; l < N_PORTS; l++) begin
         tcdm_req_o[l]   = lane_req[l];
         tcdm_wen_o[l]   = ~((state_q == ST_WR_REQ) & lane_act[l]);
         tcdm_be_o[l]    = (xfer_st & lane_act[l]) ? 4'hF : 4'h0;
         tcdm_add_o[l]   = '0;
         tcdm_wdata_o[l] = '0;
         if (xfer_st && lane_act[l]) begin
            tcdm_add_o[l] = ((state_q == ST_RD_REQ) ? src_q : dst_q)
                          + ((32'(widx_q) + 32'(l)) << 2);
         end
         if ((state_q == ST_WR_REQ) && lane_act[l]) begin
            tcdm_wdata_o[l] = mode_q ? pattern_q : rbuf_q[l];
         end
      end
   end

   assign busy_o = busy;
   assign evt_o  = {state_q == ST_ERR, state_q == ST_DONE};

endmodule

// File: tb/tb_hwpe_tcdm_streamer.sv
// Directed + randomized bench for hwpe_tcdm_streamer: a TCDM responder with random
// per-lane grant stalls and a word-level model of what each transfer must write.
module tb_hwpe_tcdm_streamer;

   localparam int unsigned N       = 4;
   localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

   logic               clk;
   logic               rst_ni;
   logic               test_mode;
   logic [31:0]        paddr, pwdata, prdata;
   logic               pwrite, psel, penable, pready, pslverr;
   logic [N-1:0]       tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
   logic [N-1:0][31:0] tcdm_add, tcdm_wdata, tcdm_r_rdata;
   logic [N-1:0][3:0]  tcdm_be;
   logic [1:0]         evt;
   logic               busy;

   hwpe_tcdm_streamer #(.N_PORTS(N), .APB_ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .test_mode_i(test_mode),
      .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite), .psel_i(psel),
      .penable_i(penable), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
      .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
      .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be), .tcdm_wdata_o(tcdm_wdata),
      .tcdm_r_rdata_i(tcdm_r_rdata), .tcdm_r_valid_i(tcdm_r_valid),
      .evt_o(evt), .busy_o(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Responder/monitor state (written only by the responder process)
   int           stall [N];
   logic [N-1:0] pend, prev_req, prev_gnt, prev_wen;
   logic [31:0]  pend_addr [N];
   logic [31:0]  prev_add [N];
   logic [31:0]  prev_wdata [N];
   logic [31:0]  resp_base;
   logic [31:0]  wr_addr [$];
   logic [31:0]  wr_data [$];
   int n_reads = 0, n_viol = 0, n_busy = 0, n_done = 0, n_err = 0, n_req = 0;

   // Transfer context (written only by the stimulus process)
   int          max_stall = 0;
   logic [31:0] cur_src, cur_dst, x_pat;
   logic        x_copy;
   int          x_len;
   int snap_w, snap_r, snap_b, snap_d, snap_e, snap_v, snap_q;

   // TCDM responder: random grant stalls, read data one cycle after grant, write log
   always @(negedge clk) begin
      if (!rst_ni) begin
         tcdm_gnt     = '0;
         tcdm_r_valid = '0;
         pend         = '0;
         prev_req     = '0;
         prev_gnt     = '0;
      end else begin
         if (busy)      n_busy++;
         if (evt[0])    n_done++;
         if (evt[1])    n_err++;
         if (|tcdm_req) n_req++;
         tcdm_r_valid = '0;
         for (int l = 0; l < N; l++) begin
            if (pend[l]) begin
               tcdm_r_valid[l] = 1'b1;
               tcdm_r_rdata[l] = pend_addr[l] ^ XOR_KEY;
               pend[l]         = 1'b0;
            end
            if (prev_req[l] && !prev_gnt[l] &&
                (tcdm_req[l] !== 1'b1 || tcdm_add[l] !== prev_add[l] ||
                 tcdm_wdata[l] !== prev_wdata[l] || tcdm_wen[l] !== prev_wen[l]))
               n_viol++;
            tcdm_gnt[l] = 1'b0;
            if (tcdm_req[l] === 1'b1) begin
               if (tcdm_be[l] !== 4'hF) n_viol++;
               if (stall[l] <= 0 || max_stall == 0) begin
                  tcdm_gnt[l] = 1'b1;
                  resp_base   = tcdm_wen[l] ? cur_src : cur_dst;
                  if ((((tcdm_add[l] - resp_base) >> 2) % 32'(N)) != 32'(l)) n_viol++;
                  if (tcdm_wen[l]) begin
                     pend[l]      = 1'b1;
                     pend_addr[l] = tcdm_add[l];
                     n_reads++;
                  end else begin
                     wr_addr.push_back(tcdm_add[l]);
                     wr_data.push_back(tcdm_wdata[l]);
                  end
                  stall[l] = int'($urandom_range(32'(max_stall), 0));
               end else begin
                  stall[l]--;
               end
            end
            prev_req[l]   = tcdm_req[l];
            prev_gnt[l]   = tcdm_gnt[l];
            prev_add[l]   = tcdm_add[l];
            prev_wdata[l] = tcdm_wdata[l];
            prev_wen[l]   = tcdm_wen[l];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      assert (obs === want) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
      end
   endtask

   // One APB transfer; entered and left just after a rising edge
   task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic se);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 32'(a); pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      rd = prdata;
      se = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic rd_reg(input string tag, input logic [4:0] a, input logic [31:0] want);
      logic [31:0] rd;
      logic        se;
      apb(1'b0, a, 32'd0, rd, se);
      check(tag, rd, want);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 32'(n < 5000), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic start_xfer(input logic copy, input logic [31:0] s, input logic [31:0] d,
                             input int len, input logic [31:0] pat, input int ms,
                             input logic clr);
      logic [31:0] rd;
      logic        se;
      max_stall = ms; cur_src = s; cur_dst = d;
      x_copy = copy; x_len = len; x_pat = pat;
      apb(1'b1, 5'h08, s, rd, se);
      apb(1'b1, 5'h0C, d, rd, se);
      apb(1'b1, 5'h10, 32'(len), rd, se);
      apb(1'b1, 5'h14, pat, rd, se);
      snap_w = wr_addr.size(); snap_r = n_reads; snap_b = n_busy;
      snap_d = n_done; snap_e = n_err; snap_v = n_viol; snap_q = n_req;
      apb(1'b1, 5'h00, {29'd0, clr, ~copy, 1'b1}, rd, se);
   endtask

   // Expected result: word i of DST holds PATTERN (fill) or f(SRC + 4i) (copy)
   task automatic finish_xfer(input string tag);
      bit          seen [logic [31:0]];
      logic [31:0] idx, want;
      int          bad, beats;
      wait_idle(tag);
      bad = 0;
      for (int k = snap_w; k < wr_addr.size(); k++) begin
         idx  = (wr_addr[k] - cur_dst) >> 2;
         want = x_copy ? ((cur_src + (idx << 2)) ^ XOR_KEY) : x_pat;
         if (idx >= 32'(x_len) || seen.exists(idx) || wr_data[k] !== want ||
             wr_addr[k][1:0] != 2'b00)
            bad++;
         seen[idx] = 1'b1;
      end
      check({tag, "_nwrites"}, 32'(wr_addr.size() - snap_w), 32'(x_len));
      check({tag, "_wdata"}, 32'(bad), 32'd0);
      check({tag, "_nreads"}, 32'(n_reads - snap_r), x_copy ? 32'(x_len) : 32'd0);
      check({tag, "_done_pulses"}, 32'(n_done - snap_d), 32'd1);
      check({tag, "_err_pulses"}, 32'(n_err - snap_e), 32'd0);
      check({tag, "_handshake"}, 32'(n_viol - snap_v), 32'd0);
      if (max_stall == 0) begin
         beats = (x_len + N - 1) / N;
         check({tag, "_busy_cycles"}, 32'(n_busy - snap_b),
               x_copy ? 32'(3 * beats + 1) : 32'(beats + 1));
      end
      rd_reg({tag, "_status"}, 5'h04, 32'h2);
   endtask

   initial begin
      logic [31:0] rd, s, d;
      logic        se, cp;
      int          n, ln;
      rst_ni = 1'b0; test_mode = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      #23;
      check("rst_req", 32'(tcdm_req), 32'h0);
      check("rst_wen", 32'(tcdm_wen), 32'hF);
      check("rst_be", 32'(tcdm_be != '0), 32'h0);
      check("rst_add", 32'(tcdm_add != '0), 32'h0);
      check("rst_wdata", 32'(tcdm_wdata != '0), 32'h0);
      check("rst_evt", 32'(evt), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_prdata", prdata, 32'h0);
      check("rst_pslverr", 32'(pslverr), 32'h0);
      @(negedge clk); rst_ni = 1'b1;
      @(posedge clk); #1;
      rd_reg("status_after_rst", 5'h04, 32'h0);

      // FILL across a partial second beat
      start_xfer(1'b0, 32'h0, 32'h1C00_0000, 6, 32'hDEAD_BEEF, 0, 1'b0);
      check("fill6_busy_t1", 32'(busy), 32'h1);
      check("fill6_req_t1", 32'(tcdm_req), 32'hF);
      finish_xfer("fill6");

      // COPY, one full beat, zero-wait grants
      start_xfer(1'b1, 32'h1C00_1000, 32'h1C00_2000, 4, 32'h0, 0, 1'b0);
      check("copy4_req_t1", 32'(tcdm_req), 32'hF);
      check("copy4_wen_t1", 32'(tcdm_wen), 32'hF);
      finish_xfer("copy4");

      // COPY with stalls; config writes while busy must be dropped
      start_xfer(1'b1, 32'h1C00_4000, 32'h1C00_5000, 13, 32'h0, 5, 1'b0);
      apb(1'b1, 5'h10, 32'd3, rd, se);
      check("busy_wr_slverr", 32'(se), 32'h0);
      rd_reg("busy_len_kept", 5'h10, 32'd13);
      rd_reg("busy_status", 5'h04, 32'h1);
      finish_xfer("copy13");

      // Misaligned DST -> error pulse, no traffic
      start_xfer(1'b0, 32'h0, 32'h1C00_0002, 4, 32'h1234_5678, 0, 1'b0);
      check("err_evt_t1", 32'(evt), 32'h2);
      check("err_busy_t1", 32'(busy), 32'h1);
      wait_idle("err_dst");
      check("err_dst_reqs", 32'(n_req - snap_q), 32'h0);
      check("err_dst_pulses", 32'(n_err - snap_e), 32'h1);
      rd_reg("err_dst_status", 5'h04, 32'h4);
      apb(1'b1, 5'h00, 32'h4, rd, se);
      rd_reg("clear_status", 5'h04, 32'h0);

      // Misaligned SRC only matters for COPY
      start_xfer(1'b1, 32'h1C00_0001, 32'h1C00_0000, 4, 32'h0, 0, 1'b0);
      check("err_src_evt_t1", 32'(evt), 32'h2);
      wait_idle("err_src");
      rd_reg("err_src_status", 5'h04, 32'h4);
      start_xfer(1'b0, 32'h1C00_0003, 32'h1C00_6000, 5, 32'hCAFE_F00D, 0, 1'b0);
      finish_xfer("fill_missrc");

      // LEN = 0: immediate done, no requests
      start_xfer(1'b1, 32'h1C00_0000, 32'h1C00_0000, 0, 32'h0, 0, 1'b0);
      check("len0_evt_t1", 32'(evt), 32'h1);
      finish_xfer("len0");
      check("len0_reqs", 32'(n_req - snap_q), 32'h0);

      // Unmapped offset
      apb(1'b0, 5'h18, 32'h0, rd, se);
      check("unmapped_rd_slverr", 32'(se), 32'h1);
      check("unmapped_rd_data", rd, 32'h0);
      apb(1'b1, 5'h18, 32'hFFFF_FFFF, rd, se);
      check("unmapped_wr_slverr", 32'(se), 32'h1);
      apb(1'b0, 5'h08, 32'h0, rd, se);
      check("mapped_rd_slverr", 32'(se), 32'h0);

      // Address wrap, and clear+start in one write
      start_xfer(1'b0, 32'h0, 32'hFFFF_FFF8, 4, 32'h5A5A_0F0F, 2, 1'b0);
      finish_xfer("fill_wrap");
      start_xfer(1'b0, 32'h0, 32'h1C00_7000, 3, 32'h0BAD_CAFE, 0, 1'b1);
      check("clrstart_busy_t1", 32'(busy), 32'h1);
      finish_xfer("clr_start");

      // Randomized transfers
      for (int t = 0; t < 5; t++) begin
         cp = 1'($urandom_range(1, 0));
         ln = int'($urandom_range(20, 1));
         s  = 32'h1C00_0000 + (32'($urandom_range(255, 0)) << 2);
         d  = 32'h1C01_0000 + (32'($urandom_range(255, 0)) << 2);
         start_xfer(cp, s, d, ln, $urandom, int'($urandom_range(3, 0)), 1'b0);
         finish_xfer($sformatf("rand%0d", t));
      end

      // Reset while a write request is pending
      start_xfer(1'b0, 32'h0, 32'h1C00_3000, 40, 32'h7777_1111, 5, 1'b0);
      n = 0;
      while (!(|(tcdm_req & ~tcdm_wen)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_found_wr", 32'(n < 200), 32'h1);
      #1 rst_ni = 1'b0;
      #1;
      check("rst_mid_req", 32'(tcdm_req), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_evt", 32'(evt), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_no_done", 32'(n_done - snap_d), 32'h0);
      rd_reg("rst_mid_status", 5'h04, 32'h0);
      rd_reg("rst_mid_len", 5'h10, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
